// File: rtl/sctag_snpq_seq.sv
// Sequencer for the two-entry JBI snoop/DMA request queue: tracks the
// four-beat request, drives per-entry beat enables and queue pointers.
// Ports: rclk/reset (async, active high), se/si/so scan,
//   jbi_sctag_req_vld (header-1 beat), arbctl_snpsel_c1 (entry consumed);
//   snp_*_wen{0,1}_s* beat enables, snpctl_wr_ptr, snpctl_rd_ptr,
//   snpq_arbctl_vld_px1 (head entry pending), sctag_jbi_iq_dequeue
//   (credit return), snpq_err (sticky protocol error).
// Optional: define SCTAG_SNPQ_ERRCHK_EN to build the protocol checker;
//   otherwise snpq_err is tied to 0.
module sctag_snpq_seq (
  input  logic rclk,
  input  logic reset,
  input  logic se,
  input  logic si,
  output logic so,
  input  logic jbi_sctag_req_vld,
  input  logic arbctl_snpsel_c1,
  output logic snp_hdr1_wen0_s0,
  output logic snp_hdr2_wen0_s1,
  output logic snp_data1_wen0_s2,
  output logic snp_data2_wen0_s3,
  output logic snp_hdr1_wen1_s0,
  output logic snp_hdr2_wen1_s1,
  output logic snp_data1_wen1_s2,
  output logic snp_data2_wen1_s3,
  output logic snpctl_wr_ptr,
  output logic snpctl_rd_ptr,
  output logic snpq_arbctl_vld_px1,
  output logic sctag_jbi_iq_dequeue,
  output logic snpq_err
);

  typedef enum logic [1:0] {
    IDLE,
    HDR2,
    DATA1,
    DATA2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] vld;
  logic [1:0] vld_nxt;
  logic       deq;
  logic       scan;
  logic       full;
  logic       req_ok;
  logic       sel_ok;
  logic [3:0] beat;
  logic [3:0] en0;
  logic [3:0] en1;

  // In IDLE the write FSM holds no entry, so occupancy is just the
  // valid count; a request is accepted only when a slot is free.
  assign full   = &vld;
  assign req_ok = (state == IDLE) & jbi_sctag_req_vld & ~full;
  assign sel_ok = arbctl_snpsel_c1 & vld[rd_ptr];

  always_comb begin
    state_nxt = state;
    beat      = 4'b0000;
    vld_nxt   = vld;
    unique case (state)
      IDLE: begin
        beat[0] = req_ok;
        if (req_ok) state_nxt = HDR2;
      end
      HDR2: begin
        beat[1]   = 1'b1;
        state_nxt = DATA1;
      end
      DATA1: begin
        beat[2]   = 1'b1;
        state_nxt = DATA2;
      end
      DATA2: begin
        beat[3]   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
    // Entry being written is never the valid head, so the set and
    // clear below never target the same bit.
    if (state == DATA2) vld_nxt[wr_ptr] = 1'b1;
    if (sel_ok) vld_nxt[rd_ptr] = 1'b0;
    // Enables are combinational; hold them low while reset is asserted.
    en0 = beat & {4{~wr_ptr & ~reset}};
    en1 = beat & {4{wr_ptr & ~reset}};
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      vld    <= 2'b00;
      deq    <= 1'b0;
      scan   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr ^ (state == DATA2);
      rd_ptr <= rd_ptr ^ sel_ok;
      vld    <= vld_nxt;
      deq    <= sel_ok;
      scan   <= se ? si : scan;
    end
  end

`ifdef SCTAG_SNPQ_ERRCHK_EN
  logic err;
  logic err_set;

  assign err_set = (jbi_sctag_req_vld & (state != IDLE))
                 | (jbi_sctag_req_vld & (state == IDLE) & full)
                 | (arbctl_snpsel_c1 & ~vld[rd_ptr]);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= err | err_set;
  end

  assign snpq_err = err;
`else
  assign snpq_err = 1'b0;
`endif

  assign snp_hdr1_wen0_s0     = en0[0];
  assign snp_hdr2_wen0_s1     = en0[1];
  assign snp_data1_wen0_s2    = en0[2];
  assign snp_data2_wen0_s3    = en0[3];
  assign snp_hdr1_wen1_s0     = en1[0];
  assign snp_hdr2_wen1_s1     = en1[1];
  assign snp_data1_wen1_s2    = en1[2];
  assign snp_data2_wen1_s3    = en1[3];
  assign snpctl_wr_ptr        = wr_ptr;
  assign snpctl_rd_ptr        = rd_ptr;
  assign snpq_arbctl_vld_px1  = vld[rd_ptr];
  assign sctag_jbi_iq_dequeue = deq;
  assign so                   = scan;

endmodule

// File: tb/tb_sctag_snpq_seq.sv
// Bench for sctag_snpq_seq: per-cycle expected enables/dequeue are
// posted to a scoreboard and checked by a negedge monitor.
module tb_sctag_snpq_seq;

`ifdef SCTAG_SNPQ_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic rclk;
  logic reset;
  logic se;
  logic si;
  logic so;
  logic req;
  logic sel;
  logic h1w0, h2w0, d1w0, d2w0;
  logic h1w1, h2w1, d1w1, d2w1;
  logic wr_ptr;
  logic rd_ptr;
  logic arb_vld;
  logic deq;
  logic err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] exp_q [int];

  sctag_snpq_seq dut (
    .rclk                 (rclk),
    .reset                (reset),
    .se                   (se),
    .si                   (si),
    .so                   (so),
    .jbi_sctag_req_vld    (req),
    .arbctl_snpsel_c1     (sel),
    .snp_hdr1_wen0_s0     (h1w0),
    .snp_hdr2_wen0_s1     (h2w0),
    .snp_data1_wen0_s2    (d1w0),
    .snp_data2_wen0_s3    (d2w0),
    .snp_hdr1_wen1_s0     (h1w1),
    .snp_hdr2_wen1_s1     (h2w1),
    .snp_data1_wen1_s2    (d1w1),
    .snp_data2_wen1_s3    (d2w1),
    .snpctl_wr_ptr        (wr_ptr),
    .snpctl_rd_ptr        (rd_ptr),
    .snpq_arbctl_vld_px1  (arb_vld),
    .sctag_jbi_iq_dequeue (deq),
    .snpq_err             (err)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) cyc = cyc + 1;

  function automatic logic [8:0] outs();
    return {deq, d2w1, d1w1, h2w1, h1w1, d2w0, d1w0, h2w0, h1w0};
  endfunction

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, act, want, cyc);
    end
  endtask

  // Scoreboard monitor: any cycle with DUT activity or an expectation.
  always @(negedge rclk) begin
    logic [8:0] v;
    logic [8:0] e;
    v = outs();
    e = exp_q.exists(cyc) ? exp_q[cyc] : 9'h000;
    if (v !== 9'h000 || e !== 9'h000) begin
      chk("beat_deq", v, e);
      if (exp_q.exists(cyc)) exp_q.delete(cyc);
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic post(input int c, input logic [8:0] bits);
    if (exp_q.exists(c)) exp_q[c] = exp_q[c] | bits;
    else exp_q[c] = bits;
  endtask

  task automatic do_req(input int entry);
    for (int b = 0; b < 4; b++)
      post(cyc + b, 9'h001 << (entry * 4 + b));
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic do_sel();
    post(cyc + 1, 9'h100);
    sel = 1'b1;
    step();
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    se    = 1'b0;
    si    = 1'b0;
    req   = 1'b0;
    sel   = 1'b0;
    step();
    step();
    chk("rst_outs", outs(), 9'h000);
    chk("rst_wr", {8'h0, wr_ptr}, 9'h000);
    chk("rst_rd", {8'h0, rd_ptr}, 9'h000);
    chk("rst_arb", {8'h0, arb_vld}, 9'h000);
    chk("rst_err", {8'h0, err}, 9'h000);
    reset = 1'b0;
    step();

    // single request into entry 0, then back-to-back into entry 1
    do_req(0);
    step(); step(); step();
    chk("t4_wr", {8'h0, wr_ptr}, 9'h001);
    chk("t4_arb", {8'h0, arb_vld}, 9'h001);
    chk("t4_rd", {8'h0, rd_ptr}, 9'h000);
    do_req(1);
    step(); step(); step();
    chk("t8_wr", {8'h0, wr_ptr}, 9'h000);
    chk("t8_arb", {8'h0, arb_vld}, 9'h001);
    // third request with queue full is dropped
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("full_err", {8'h0, err}, {8'h0, ERR_EXP});

    // consecutive selects drain both entries
    do_sel();
    chk("c1_rd", {8'h0, rd_ptr}, 9'h001);
    chk("c1_arb", {8'h0, arb_vld}, 9'h001);
    do_sel();
    chk("c2_rd", {8'h0, rd_ptr}, 9'h000);
    chk("c2_arb", {8'h0, arb_vld}, 9'h000);
    step();

    // DATA2 of entry 1 coincides with select of entry 0
    do_req(0);
    step(); step(); step();
    do_req(1);
    step(); step();
    do_sel();
    chk("sim_rd", {8'h0, rd_ptr}, 9'h001);
    chk("sim_arb", {8'h0, arb_vld}, 9'h001);
    chk("sim_wr", {8'h0, wr_ptr}, 9'h000);
    do_sel();
    chk("sim_v0", {8'h0, arb_vld}, 9'h000);
    chk("sim_rd2", {8'h0, rd_ptr}, 9'h000);
    step();

    // reset during DATA1 of a partial entry-1 request
    do_req(0);
    step(); step(); step();
    post(cyc, 9'h010);
    post(cyc + 1, 9'h020);
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mid_outs", outs(), 9'h000);
    chk("mid_ptrs", {7'h0, wr_ptr, rd_ptr}, 9'h000);
    chk("mid_arb", {8'h0, arb_vld}, 9'h000);
    chk("mid_err", {8'h0, err}, 9'h000);
    step();
    reset = 1'b0;
    chk("post_arb", {8'h0, arb_vld}, 9'h000);
    step();

    // request beat during HDR2 is ignored by the FSM
    do_req(0);
    req = 1'b1;
    step();
    req = 1'b0;
    step(); step();
    chk("h2_arb", {8'h0, arb_vld}, 9'h001);
    chk("h2_wr", {8'h0, wr_ptr}, 9'h001);
    chk("h2_err", {8'h0, err}, {8'h0, ERR_EXP});
    do_sel();
    chk("h2_drain", {8'h0, arb_vld}, 9'h000);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
